// File: rtl/mips_enc_pkg.sv
// Shared types, encoding constants and word-packing helpers for the MIPS instruction encoder.
package mips_enc_pkg;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,
        MN_SUB  = 5'd1,
        MN_AND  = 5'd2,
        MN_OR   = 5'd3,
        MN_XOR  = 5'd4,
        MN_SLL  = 5'd5,
        MN_SRL  = 5'd6,
        MN_SRA  = 5'd7,
        MN_JR   = 5'd8,
        MN_ADDI = 5'd9,
        MN_ANDI = 5'd10,
        MN_ORI  = 5'd11,
        MN_XORI = 5'd12,
        MN_LW   = 5'd13,
        MN_SW   = 5'd14,
        MN_BEQ  = 5'd15,
        MN_BNE  = 5'd16,
        MN_LUI  = 5'd17,
        MN_J    = 5'd18,
        MN_JAL  = 5'd19,
        MN_LI   = 5'd20
    } mnem_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_LI_LO = 1'b1
    } enc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SH_LSB    = 6;
    localparam int FN_LSB    = 0;
    localparam int IMM_LSB   = 0;
    localparam int TGT_LSB   = 0;

    function automatic logic [31:0] enc_r(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] shamt,
        input logic [5:0] funct
    );
        logic [31:0] w;
        w                  = 32'h0000_0000;
        w[OP_LSB  +: 6]    = OP_RTYPE;
        w[RS_LSB  +: 5]    = rs;
        w[RT_LSB  +: 5]    = rt;
        w[RD_LSB  +: 5]    = rd;
        w[SH_LSB  +: 5]    = shamt;
        w[FN_LSB  +: 6]    = funct;
        return w;
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm16
    );
        logic [31:0] w;
        w                  = 32'h0000_0000;
        w[OP_LSB  +: 6]    = op;
        w[RS_LSB  +: 5]    = rs;
        w[RT_LSB  +: 5]    = rt;
        w[IMM_LSB +: 16]   = imm16;
        return w;
    endfunction

    function automatic logic [31:0] enc_j(
        input logic [5:0]  op,
        input logic [25:0] target
    );
        logic [31:0] w;
        w                  = 32'h0000_0000;
        w[OP_LSB  +: 6]    = op;
        w[TGT_LSB +: 26]   = target;
        return w;
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: mnemonic plus fields to a 32-bit MIPS word; LI yields its LUI half.
module mips_instr_pack
    import mips_enc_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        is_li
);

    // Field selection per mnemonic; unused fields are tied to zero
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        is_li   = 1'b0;
        case (mnem)
            MN_ADD:  word = enc_r(rs, rt, rd, 5'd0, FN_ADD);
            MN_SUB:  word = enc_r(rs, rt, rd, 5'd0, FN_SUB);
            MN_AND:  word = enc_r(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:   word = enc_r(rs, rt, rd, 5'd0, FN_OR);
            MN_XOR:  word = enc_r(rs, rt, rd, 5'd0, FN_XOR);
            MN_SLL:  word = enc_r(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:  word = enc_r(5'd0, rt, rd, shamt, FN_SRL);
            MN_SRA:  word = enc_r(5'd0, rt, rd, shamt, FN_SRA);
            MN_JR:   word = enc_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_ADDI: word = enc_i(OP_ADDI, rs, rt, imm[15:0]);
            MN_ANDI: word = enc_i(OP_ANDI, rs, rt, imm[15:0]);
            MN_ORI:  word = enc_i(OP_ORI,  rs, rt, imm[15:0]);
            MN_XORI: word = enc_i(OP_XORI, rs, rt, imm[15:0]);
            MN_LW:   word = enc_i(OP_LW,   rs, rt, imm[15:0]);
            MN_SW:   word = enc_i(OP_SW,   rs, rt, imm[15:0]);
            MN_BEQ:  word = enc_i(OP_BEQ,  rs, rt, imm[15:0]);
            MN_BNE:  word = enc_i(OP_BNE,  rs, rt, imm[15:0]);
            MN_LUI:  word = enc_i(OP_LUI, 5'd0, rt, imm[15:0]);
            MN_J:    word = enc_j(OP_J,   imm[25:0]);
            MN_JAL:  word = enc_j(OP_JAL, imm[25:0]);
            MN_LI: begin
                word  = enc_i(OP_LUI, 5'd0, rt, imm[31:16]);
                is_li = 1'b1;
            end
            default: begin
                word    = 32'h0000_0000;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Instruction encoder writing packed MIPS words into imem at an auto-incrementing address.
// Optional build macro MIPS_ENC_LI_COMPACT_EN: LI with a zero upper half emits a single ORI.
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_illegal,
    output logic [15:0]       word_count
);

    enc_state_e        state_r;
    enc_state_e        state_next_s;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              err_illegal_r;
    logic [15:0]       word_count_r;
    logic [4:0]        lo_rt_r;
    logic [15:0]       lo_imm_r;

    logic [31:0]       pack_word_s;
    logic              pack_illegal_s;
    logic              pack_is_li_s;
    logic              out_free_s;
    logic              transfer_s;
    logic              accept_s;
    logic              base_take_s;
    logic              li_short_s;
    logic              emit_s;
    logic [31:0]       emit_word_s;

    mips_instr_pack u_pack (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .word    (pack_word_s),
        .illegal (pack_illegal_s),
        .is_li   (pack_is_li_s)
    );

    assign transfer_s  = imem_we_r & imem_ready;
    assign out_free_s  = ~imem_we_r | imem_ready;
    assign in_ready    = ~reset & (state_r == ST_IDLE) & ~base_load & out_free_s;
    assign accept_s    = in_valid & in_ready;
    assign base_take_s = base_load & (state_r == ST_IDLE) & ~imem_we_r;

`ifdef MIPS_ENC_LI_COMPACT_EN
    assign li_short_s = pack_is_li_s & (in_imm[31:16] == 16'h0000);
`else
    assign li_short_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: LI parks in LI_LO until the LUI word leaves the output register
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && pack_is_li_s && !li_short_s) begin
                    state_next_s = ST_LI_LO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LI_LO: begin
                if (out_free_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LI_LO;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: which word, if any, loads the output register this cycle
    always_comb begin
        emit_s      = 1'b0;
        emit_word_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !pack_illegal_s) begin
                    emit_s = 1'b1;
                    if (li_short_s) begin
                        emit_word_s = enc_i(OP_ORI, 5'd0, in_rt, in_imm[15:0]);
                    end else begin
                        emit_word_s = pack_word_s;
                    end
                end else begin
                    emit_s = 1'b0;
                end
            end
            ST_LI_LO: begin
                if (out_free_s) begin
                    emit_s      = 1'b1;
                    emit_word_s = enc_i(OP_ORI, lo_rt_r, lo_rt_r, lo_imm_r);
                end else begin
                    emit_s = 1'b0;
                end
            end
            default: begin
                emit_s      = 1'b0;
                emit_word_s = 32'h0000_0000;
            end
        endcase
    end

    // Output register, address pointer, counters and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            imem_we_r     <= 1'b0;
            imem_addr_r   <= '0;
            imem_wdata_r  <= 32'h0000_0000;
            err_illegal_r <= 1'b0;
            word_count_r  <= 16'h0000;
            lo_rt_r       <= 5'd0;
            lo_imm_r      <= 16'h0000;
        end else begin
            if (emit_s) begin
                imem_we_r    <= 1'b1;
                imem_wdata_r <= emit_word_s;
            end else if (transfer_s) begin
                imem_we_r <= 1'b0;
            end
            // base_take_s implies imem_we_r==0, so it never races a transfer
            if (base_take_s) begin
                imem_addr_r <= base_addr;
            end else if (transfer_s) begin
                imem_addr_r <= imem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (transfer_s && (word_count_r != 16'hFFFF)) begin
                word_count_r <= word_count_r + 16'd1;
            end
            if (accept_s && pack_illegal_s) begin
                err_illegal_r <= 1'b1;
            end
            if (accept_s && pack_is_li_s) begin
                lo_rt_r  <= in_rt;
                lo_imm_r <= in_imm[15:0];
            end
        end
    end

    assign imem_we     = imem_we_r;
    assign imem_addr   = imem_addr_r;
    assign imem_wdata  = imem_wdata_r;
    assign err_illegal = err_illegal_r;
    assign word_count  = word_count_r;

endmodule
